// File: rtl/cpu_pkg.sv
// Shared opcodes, state encoding, ALU codes and the
// datapath strobe bundle for the single-bus CPU.
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_SUB = 5'b00100;
  localparam logic [4:0] ALU_AND = 5'b00101;
  localparam logic [4:0] ALU_OR  = 5'b00110;

  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    T0      = 4'd1,
    T1      = 4'd2,
    T2      = 4'd3,
    T3      = 4'd4,
    T4      = 4'd5,
    T5      = 4'd6,
    T6      = 4'd7,
    T7      = 4'd8,
    S_HALT  = 4'd9
  } state_t;

  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic y_in;
    logic z_in;
    logic zlo_out;
    logic pc_in;
    logic inc_pc;
    logic read;
    logic write;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
    logic ba_out;
    logic c_out;
    logic con_in;
  } strobes_t;

  function automatic logic is_mem(input logic [4:0] op);
    return op == OP_LD || op == OP_LDI || op == OP_ST;
  endfunction

  function automatic logic is_rr(input logic [4:0] op);
    return op == OP_ADD || op == OP_SUB ||
           op == OP_AND || op == OP_OR;
  endfunction

  function automatic logic is_ri(input logic [4:0] op);
    return op == OP_ADDI || op == OP_ANDI || op == OP_ORI;
  endfunction

  function automatic logic [4:0] ri_alu(input logic [4:0] op);
    unique case (op)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/control_decode.sv
// Moore output decode: {state, opcode, CON} to datapath
// strobes and ALU function.
import cpu_pkg::*;

module control_decode (
  input  state_t     state,
  input  logic [4:0] opcode,
  input  logic       con,
  output strobes_t   strobes,
  output logic [4:0] alu_op
);

  always_comb begin
    strobes = '0;
    alu_op  = '0;
    unique case (state)
      T0: begin
        strobes.pc_out = 1'b1;
        strobes.mar_in = 1'b1;
      end
      T1: begin
        strobes.read   = 1'b1;
        strobes.mdr_in = 1'b1;
        strobes.pc_in  = 1'b1;
        strobes.inc_pc = 1'b1;
      end
      T2: begin
        strobes.mdr_out = 1'b1;
        strobes.ir_in   = 1'b1;
      end
      T3: begin
        if (is_mem(opcode)) begin
          strobes.grb    = 1'b1;
          strobes.ba_out = 1'b1;
          strobes.y_in   = 1'b1;
        end else if (is_rr(opcode) || is_ri(opcode)) begin
          strobes.grb   = 1'b1;
          strobes.r_out = 1'b1;
          strobes.y_in  = 1'b1;
        end else if (opcode == OP_BR) begin
          strobes.gra    = 1'b1;
          strobes.r_out  = 1'b1;
          strobes.con_in = 1'b1;
        end else if (opcode == OP_JR) begin
          strobes.gra   = 1'b1;
          strobes.r_out = 1'b1;
          strobes.pc_in = 1'b1;
        end
      end
      T4: begin
        if (is_mem(opcode)) begin
          strobes.c_out = 1'b1;
          strobes.z_in  = 1'b1;
          alu_op        = ALU_ADD;
        end else if (is_rr(opcode)) begin
          strobes.grc   = 1'b1;
          strobes.r_out = 1'b1;
          strobes.z_in  = 1'b1;
          alu_op        = opcode;
        end else if (is_ri(opcode)) begin
          strobes.c_out = 1'b1;
          strobes.z_in  = 1'b1;
          alu_op        = ri_alu(opcode);
        end else if (opcode == OP_BR) begin
          strobes.pc_out = 1'b1;
          strobes.y_in   = 1'b1;
        end
      end
      T5: begin
        if (opcode == OP_LD || opcode == OP_ST) begin
          strobes.zlo_out = 1'b1;
          strobes.mar_in  = 1'b1;
        end else if (opcode == OP_LDI || is_rr(opcode) ||
                     is_ri(opcode)) begin
          strobes.zlo_out = 1'b1;
          strobes.gra     = 1'b1;
          strobes.r_in    = 1'b1;
        end else if (opcode == OP_BR) begin
          strobes.c_out = 1'b1;
          strobes.z_in  = 1'b1;
          alu_op        = ALU_ADD;
        end
      end
      T6: begin
        if (opcode == OP_LD) begin
          strobes.read   = 1'b1;
          strobes.mdr_in = 1'b1;
        end else if (opcode == OP_ST) begin
          strobes.gra    = 1'b1;
          strobes.r_out  = 1'b1;
          strobes.mdr_in = 1'b1;
        end else if (opcode == OP_BR) begin
          strobes.zlo_out = 1'b1;
          strobes.pc_in   = con;
        end
      end
      T7: begin
        if (opcode == OP_LD) begin
          strobes.mdr_out = 1'b1;
          strobes.gra     = 1'b1;
          strobes.r_in    = 1'b1;
        end else if (opcode == OP_ST) begin
          strobes.write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore sequencer: state register, next-state
// logic and the datapath control port.
import cpu_pkg::*;

module control_sequencer (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] IR,
  input  logic        CON,
  output logic        PCout,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        ZLOout,
  output logic        PCin,
  output logic        IncPC,
  output logic        Read,
  output logic        write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic        CONin,
  output logic [4:0]  AluOp,
  output logic        Run,
  output logic        HIin,
  output logic        LOin,
  output logic        HIout,
  output logic        LOout,
  output logic        ZHIout,
  output logic        INPORTout,
  output logic        OUTPORTin,
  output logic        OUTPORTout,
  output logic        Yout
);

  state_t     state;
  state_t     state_d;
  strobes_t   strobes;
  logic [4:0] opcode;
  logic       unused_ir;

  assign opcode    = IR[31:27];
  assign unused_ir = ^IR[26:0];

  always_ff @(posedge Clock) begin
    if (Reset) state <= S_RESET;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_RESET: state_d = T0;
      T0:      state_d = T1;
      T1:      state_d = T2;
      T2:      state_d = T3;
      T3: begin
        if (opcode == OP_HALT)
          state_d = S_HALT;
        else if (is_mem(opcode) || is_rr(opcode) ||
                 is_ri(opcode) || opcode == OP_BR)
          state_d = T4;
        else
          state_d = T0;
      end
      T4:      state_d = T5;
      T5: begin
        if (opcode == OP_LD || opcode == OP_ST ||
            opcode == OP_BR)
          state_d = T6;
        else
          state_d = T0;
      end
      T6: begin
        if (opcode == OP_LD || opcode == OP_ST)
          state_d = T7;
        else
          state_d = T0;
      end
      T7:      state_d = T0;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  control_decode u_decode (
    .state   (state),
    .opcode  (opcode),
    .con     (CON),
    .strobes (strobes),
    .alu_op  (AluOp)
  );

  assign PCout  = strobes.pc_out;
  assign MARin  = strobes.mar_in;
  assign MDRin  = strobes.mdr_in;
  assign MDRout = strobes.mdr_out;
  assign IRin   = strobes.ir_in;
  assign Yin    = strobes.y_in;
  assign Zin    = strobes.z_in;
  assign ZLOout = strobes.zlo_out;
  assign PCin   = strobes.pc_in;
  assign IncPC  = strobes.inc_pc;
  assign Read   = strobes.read;
  assign write  = strobes.write;
  assign Gra    = strobes.gra;
  assign Grb    = strobes.grb;
  assign Grc    = strobes.grc;
  assign Rin    = strobes.r_in;
  assign Rout   = strobes.r_out;
  assign BAout  = strobes.ba_out;
  assign Cout   = strobes.c_out;
  assign CONin  = strobes.con_in;

  assign Run = (state != S_RESET) && (state != S_HALT);

  assign HIin       = 1'b0;
  assign LOin       = 1'b0;
  assign HIout      = 1'b0;
  assign LOout      = 1'b0;
  assign ZHIout     = 1'b0;
  assign INPORTout  = 1'b0;
  assign OUTPORTin  = 1'b0;
  assign OUTPORTout = 1'b0;
  assign Yout       = 1'b0;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks each
// instruction class step by step against hand tables.
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] IR    = '0;
  logic        CON   = 1'b0;
  logic PCout, MARin, MDRin, MDRout, IRin, Yin, Zin;
  logic ZLOout, PCin, IncPC, Read, write;
  logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin;
  logic [4:0] AluOp;
  logic Run;
  logic HIin, LOin, HIout, LOout, ZHIout;
  logic INPORTout, OUTPORTin, OUTPORTout, Yout;

  int checks = 0;
  int errors = 0;

  localparam logic [19:0] PCO  = 20'h1 << 19;
  localparam logic [19:0] MARI = 20'h1 << 18;
  localparam logic [19:0] MDRI = 20'h1 << 17;
  localparam logic [19:0] MDRO = 20'h1 << 16;
  localparam logic [19:0] IRI  = 20'h1 << 15;
  localparam logic [19:0] YI   = 20'h1 << 14;
  localparam logic [19:0] ZI   = 20'h1 << 13;
  localparam logic [19:0] ZLO  = 20'h1 << 12;
  localparam logic [19:0] PCI  = 20'h1 << 11;
  localparam logic [19:0] INC  = 20'h1 << 10;
  localparam logic [19:0] RD   = 20'h1 << 9;
  localparam logic [19:0] WR   = 20'h1 << 8;
  localparam logic [19:0] GA   = 20'h1 << 7;
  localparam logic [19:0] GB   = 20'h1 << 6;
  localparam logic [19:0] GC   = 20'h1 << 5;
  localparam logic [19:0] RI   = 20'h1 << 4;
  localparam logic [19:0] RO   = 20'h1 << 3;
  localparam logic [19:0] BAO  = 20'h1 << 2;
  localparam logic [19:0] CO   = 20'h1 << 1;
  localparam logic [19:0] CONI = 20'h1;

  localparam logic [19:0] F0 = PCO | MARI;
  localparam logic [19:0] F1 = RD | MDRI | PCI | INC;
  localparam logic [19:0] F2 = MDRO | IRI;

  localparam logic [31:0] IR_ST   = 32'h12200090;
  localparam logic [31:0] IR_LD   = 32'h00900055;
  localparam logic [31:0] IR_BR   = 32'h92800010;
  localparam logic [31:0] IR_HALT = 32'hD8000000;
  localparam logic [31:0] IR_NOP  = 32'hD0000000;

  control_sequencer dut (
    .Clock(Clock), .Reset(Reset), .IR(IR), .CON(CON),
    .PCout(PCout), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .ZLOout(ZLOout), .PCin(PCin), .IncPC(IncPC),
    .Read(Read), .write(write), .Gra(Gra), .Grb(Grb),
    .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .Cout(Cout), .CONin(CONin), .AluOp(AluOp), .Run(Run),
    .HIin(HIin), .LOin(LOin), .HIout(HIout),
    .LOout(LOout), .ZHIout(ZHIout),
    .INPORTout(INPORTout), .OUTPORTin(OUTPORTin),
    .OUTPORTout(OUTPORTout), .Yout(Yout)
  );

  always #5 Clock = ~Clock;

  function automatic logic [19:0] sig();
    return {PCout, MARin, MDRin, MDRout, IRin, Yin, Zin,
            ZLOout, PCin, IncPC, Read, write, Gra, Grb,
            Grc, Rin, Rout, BAout, Cout, CONin};
  endfunction

  function automatic logic [8:0] tied();
    return {HIin, LOin, HIout, LOout, ZHIout, INPORTout,
            OUTPORTin, OUTPORTout, Yout};
  endfunction

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    IR    = IR_ST;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({sig(), AluOp, Run} !== 26'h0) begin
        errors++;
        $display("FAIL reset cyc %0d got %h/%h/%b want 0",
                 k, sig(), AluOp, Run);
      end
    end
    checks++;
    if (tied() !== 9'h0) begin
      errors++;
      $display("FAIL tied got %h want 0", tied());
    end
    Reset = 1'b0;
    step();
    checks++;
    if (sig() !== F0 || Run !== 1'b1) begin
      errors++;
      $display("FAIL first_t0 got %h run %b want %h run 1",
               sig(), Run, F0);
    end
  endtask

  task automatic test_store();
    logic [19:0] e [8];
    e = '{F0, F1, F2, GB | BAO | YI, CO | ZI, ZLO | MARI,
          GA | RO | MDRI, WR};
    IR = IR_ST;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (sig() !== e[k] || Run !== 1'b1) begin
        errors++;
        $display("FAIL st t%0d got %h run %b want %h",
                 k, sig(), Run, e[k]);
      end
      checks++;
      if (AluOp !== (k == 4 ? 5'b00011 : 5'b0)) begin
        errors++;
        $display("FAIL st_alu t%0d got %b", k, AluOp);
      end
      step();
    end
    checks++;
    if (sig() !== F0) begin
      errors++;
      $display("FAIL st_end got %h want %h", sig(), F0);
    end
  endtask

  task automatic test_load();
    logic [19:0] e [8];
    e = '{F0, F1, F2, GB | BAO | YI, CO | ZI, ZLO | MARI,
          RD | MDRI, MDRO | GA | RI};
    IR = IR_LD;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (sig() !== e[k] || Run !== 1'b1) begin
        errors++;
        $display("FAIL ld t%0d got %h run %b want %h",
                 k, sig(), Run, e[k]);
      end
      checks++;
      if (AluOp !== (k == 4 ? 5'b00011 : 5'b0)) begin
        errors++;
        $display("FAIL ld_alu t%0d got %b", k, AluOp);
      end
      step();
    end
    checks++;
    if (sig() !== F0) begin
      errors++;
      $display("FAIL ld_end got %h want %h", sig(), F0);
    end
  endtask

  task automatic test_branch(input logic c);
    logic [19:0] e [7];
    e = '{F0, F1, F2, GA | RO | CONI, PCO | YI, CO | ZI,
          ZLO | (c ? PCI : 20'h0)};
    IR  = IR_BR;
    CON = c;
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (sig() !== e[k] || Run !== 1'b1) begin
        errors++;
        $display("FAIL br%0b t%0d got %h want %h",
                 c, k, sig(), e[k]);
      end
      checks++;
      if (AluOp !== (k == 5 ? 5'b00011 : 5'b0)) begin
        errors++;
        $display("FAIL br_alu t%0d got %b", k, AluOp);
      end
      step();
    end
    checks++;
    if (sig() !== F0) begin
      errors++;
      $display("FAIL br%0b_end got %h want %h", c, sig(), F0);
    end
    CON = 1'b0;
  endtask

  task automatic test_alu();
    logic [31:0] ir_t [5];
    logic [19:0] e4_t [5];
    logic [4:0]  a_t  [5];
    logic [19:0] e [6];
    ir_t = '{32'h18000000, 32'h20000000, 32'h30000000,
             32'h60000000, 32'h70000000};
    e4_t = '{GC | RO | ZI, GC | RO | ZI, GC | RO | ZI,
             CO | ZI, CO | ZI};
    a_t  = '{5'b00011, 5'b00100, 5'b00110,
             5'b00011, 5'b00110};
    for (int i = 0; i < 5; i++) begin
      IR = ir_t[i];
      e  = '{F0, F1, F2, GB | RO | YI, e4_t[i],
             ZLO | GA | RI};
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (sig() !== e[k]) begin
          errors++;
          $display("FAIL alu %h t%0d got %h want %h",
                   ir_t[i], k, sig(), e[k]);
        end
        checks++;
        if (AluOp !== (k == 4 ? a_t[i] : 5'b0)) begin
          errors++;
          $display("FAIL aluop %h t%0d got %b want %b",
                   ir_t[i], k, AluOp, a_t[i]);
        end
        step();
      end
      checks++;
      if (sig() !== F0) begin
        errors++;
        $display("FAIL alu_end %h got %h", ir_t[i], sig());
      end
    end
  endtask

  task automatic test_short();
    logic [31:0] ir_t [3];
    logic [19:0] e3_t [3];
    logic [19:0] e [4];
    ir_t = '{32'hA0000000, IR_NOP, 32'h38000000};
    e3_t = '{GA | RO | PCI, 20'h0, 20'h0};
    for (int i = 0; i < 3; i++) begin
      IR = ir_t[i];
      e  = '{F0, F1, F2, e3_t[i]};
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (sig() !== e[k] || Run !== 1'b1) begin
          errors++;
          $display("FAIL short %h t%0d got %h want %h",
                   ir_t[i], k, sig(), e[k]);
        end
        step();
      end
      checks++;
      if (sig() !== F0) begin
        errors++;
        $display("FAIL short_end %h got %h", ir_t[i], sig());
      end
    end
  endtask

  task automatic test_store_abort();
    IR = IR_ST;
    for (int k = 0; k < 6; k++) step();
    checks++;
    if (sig() !== (GA | RO | MDRI)) begin
      errors++;
      $display("FAIL abort_t6 got %h", sig());
    end
    Reset = 1'b1;
    step();
    checks++;
    if (sig() !== 20'h0 || Run !== 1'b0) begin
      errors++;
      $display("FAIL abort_rst got %h run %b want 0",
               sig(), Run);
    end
    Reset = 1'b0;
    IR    = IR_NOP;
    step();
    checks++;
    if (sig() !== F0) begin
      errors++;
      $display("FAIL abort_t0 got %h want %h", sig(), F0);
    end
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (write !== 1'b0) begin
        errors++;
        $display("FAIL abort_write cyc %0d got %b want 0",
                 k, write);
      end
      step();
    end
  endtask

  task automatic test_halt();
    IR = IR_HALT;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (Run !== 1'b1) begin
        errors++;
        $display("FAIL halt_run t%0d got %b want 1", k, Run);
      end
      step();
    end
    for (int k = 0; k < 22; k++) begin
      checks++;
      if ({sig(), AluOp, Run} !== 26'h0) begin
        errors++;
        $display("FAIL halted cyc %0d got %h/%h/%b want 0",
                 k, sig(), AluOp, Run);
      end
      step();
    end
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    IR    = IR_NOP;
    step();
    checks++;
    if (sig() !== F0 || Run !== 1'b1) begin
      errors++;
      $display("FAIL halt_restart got %h run %b", sig(), Run);
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_branch(1'b1);
    test_branch(1'b0);
    test_alu();
    test_short();
    test_store_abort();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
